// File: rtl/ram8w16_ctrl_if.sv
// Request/response bundle for the ram8w16_ctrl register bank.
// The master drives requests and the slave returns registered read data.
interface ram8w16_ctrl_if #(
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = 3
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AddrW-1:0] req_addr;
  logic [Width-1:0] req_wdata;
  logic             rsp_valid;
  logic [Width-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram8w16_ctrl.sv
// Register-bank endpoint: demuxed writes, muxed registered reads, and a
// sequenced clear-all engine that zeroes one word per cycle.
module ram8w16_ctrl #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8,
  parameter int unsigned AddrW = 3
) (
  input  logic           clk,
  input  logic           rst,
  ram8w16_ctrl_if.slave  bus_io,
  input  logic           clr_start_i,
  output logic           busy_o
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic             rsp_valid_q, rsp_valid_d;
  logic [Width-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             accept, wr_en, rd_en;

  // Ready drops combinationally on clr_start so a clear always beats a request.
  assign bus_io.req_ready = (state_q == StIdle) & ~clr_start_i & ~rst;
  assign accept           = bus_io.req_valid & bus_io.req_ready;
  assign wr_en            = accept & bus_io.req_we;
  assign rd_en            = accept & ~bus_io.req_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_start_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + AddrW'(1);
        if (cnt_q == AddrW'(Depth - 1)) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_comb begin
    rsp_valid_d = rd_en;
    rsp_rdata_d = rd_en ? mem_q[bus_io.req_addr] : rsp_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[bus_io.req_addr] <= bus_io.req_wdata;
    end else if (state_q == StClear) begin
      mem_q[cnt_q] <= '0;
    end
  end

  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_rdata = rsp_rdata_q;
  assign busy_o           = (state_q == StClear);

endmodule

// File: tb/tb_ram8w16_ctrl.sv
// Directed bench for ram8w16_ctrl: writes, back-to-back reads, clear engine,
// clear/request collision and reset aborts.
module tb_ram8w16_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_start = 1'b0;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  ram8w16_ctrl_if #(.Width(16), .AddrW(3)) bus ();

  ram8w16_ctrl #(.Width(16), .Depth(8), .AddrW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_io      (bus.slave),
    .clr_start_i (clr_start),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    chk("wr_ready", {15'd0, bus.req_ready}, 16'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    tick();
    bus.req_valid = 1'b0;
    chk({tag, "_vld"}, {15'd0, bus.rsp_valid}, 16'd1);
    chk(tag, bus.rsp_rdata, exp);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state
    #2;
    chk("rst_ready", {15'd0, bus.req_ready}, 16'd0);
    chk("rst_rvld",  {15'd0, bus.rsp_valid}, 16'd0);
    chk("rst_rdata", bus.rsp_rdata, 16'h0000);
    chk("rst_busy",  {15'd0, busy}, 16'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("idle_ready", {15'd0, bus.req_ready}, 16'd1);

    // Single write then read
    wr(3'd3, 16'h1234);
    rd("rd3", 3'd3, 16'h1234);
    tick();
    chk("hold_vld", {15'd0, bus.rsp_valid}, 16'd0);
    chk("hold_data", bus.rsp_rdata, 16'h1234);
    tick();
    chk("hold_data2", bus.rsp_rdata, 16'h1234);

    // Fill and back-to-back reads
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hA000 + 16'(i));
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.req_addr = 3'(i);
      tick();
      chk("b2b_vld", {15'd0, bus.rsp_valid}, 16'd1);
      chk("b2b_data", bus.rsp_rdata, 16'hA000 + 16'(i));
    end
    bus.req_valid = 1'b0;
    tick();
    chk("b2b_end", {15'd0, bus.rsp_valid}, 16'd0);

    // Clear-all with a stray clr_start mid-sequence
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF);
    clr_start = 1'b1;
    #1;
    chk("clr_ready_comb", {15'd0, bus.req_ready}, 16'd0);
    tick();
    clr_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      clr_start = (c == 3);
      #1;
      chk("clr_busy", {15'd0, busy}, 16'd1);
      chk("clr_ready", {15'd0, bus.req_ready}, 16'd0);
      tick();
    end
    clr_start = 1'b0;
    #1;
    chk("clr_done_busy", {15'd0, busy}, 16'd0);
    chk("clr_done_ready", {15'd0, bus.req_ready}, 16'd1);
    for (int i = 0; i < 8; i++) rd("clr_rd", 3'(i), 16'h0000);

    // Clear and write in the same cycle: clear wins
    wr(3'd5, 16'h7777);
    clr_start     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 3'd5;
    bus.req_wdata = 16'h5555;
    #1;
    chk("coll_ready", {15'd0, bus.req_ready}, 16'd0);
    tick();
    clr_start     = 1'b0;
    bus.req_valid = 1'b0;
    chk("coll_busy", {15'd0, busy}, 16'd1);
    for (int c = 0; c < 8; c++) tick();
    chk("coll_done", {15'd0, busy}, 16'd0);
    rd("coll_rd5", 3'd5, 16'h0000);

    // Reset during CLEAR: later words must still end up zero
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF);
    rd("pre_rst", 3'd7, 16'hFFFF);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    #1;
    chk("rc_busy",  {15'd0, busy}, 16'd0);
    chk("rc_ready", {15'd0, bus.req_ready}, 16'd0);
    chk("rc_rdata", bus.rsp_rdata, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    chk("rc_post_vld", {15'd0, bus.rsp_valid}, 16'd0);
    chk("rc_post_busy", {15'd0, busy}, 16'd0);
    for (int i = 0; i < 8; i++) rd("rc_rd", 3'(i), 16'h0000);

    // Reset one cycle after a read accept
    wr(3'd2, 16'hBEEF);
    rd("rr_rd2", 3'd2, 16'hBEEF);
    rst = 1'b1;
    #1;
    chk("rr_vld", {15'd0, bus.rsp_valid}, 16'd0);
    chk("rr_rdata", bus.rsp_rdata, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    chk("rr_post_vld", {15'd0, bus.rsp_valid}, 16'd0);
    rd("rr_rd2_after", 3'd2, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
